// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Program-counter register and single-outstanding instruction
//                fetch sequencer. Boots from StartPC, requests one word at a
//                time, holds it until the consumer retires it, then moves to
//                NextPC. Any misaligned PC parks the unit in a sticky fault.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [31:0] StartPC,
  input  logic [31:0] NextPC,
  output logic [31:0] CurrentPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic        Fault,
  output logic [31:0] RetireCount
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_fault;
  logic [31:0] r_retire_cnt;

  logic        w_imem_req;
  logic        w_boot;
  logic        w_fill;
  logic        w_retire;

  // Next-state and per-cycle control; NextPC is only looked at when retiring
  // so an undefined NextPC outside a retire cannot leak into the state.
  always_comb begin
    w_state_nxt = r_state;
    w_imem_req  = 1'b0;
    w_boot      = 1'b0;
    w_fill      = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_boot      = 1'b1;
        w_state_nxt = (StartPC[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
      end
      ST_REQ: begin
        w_imem_req = 1'b1;
        if (IMemAck) begin
          w_fill      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (InstrReady) begin
          w_retire    = 1'b1;
          w_state_nxt = (NextPC[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_FAULT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) r_state <= ST_BOOT;
    else          r_state <= w_state_nxt;
  end

  // PC moves only at boot or on a retire (a misaligned target is still kept for debug).
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)      r_pc <= 32'd0;
    else if (w_boot)   r_pc <= StartPC;
    else if (w_retire) r_pc <= NextPC;
  end

  // Capture the fetched word on ack; valid drops when the word is retired.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_instr <= 32'd0;
      r_valid <= 1'b0;
    end else if (w_fill) begin
      r_instr <= IMemData;
      r_valid <= 1'b1;
    end else if (w_retire) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky fault: set on any entry into the fault state, cleared only by reset.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)                    r_fault <= 1'b0;
    else if (w_state_nxt == ST_FAULT) r_fault <= 1'b1;
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)      r_retire_cnt <= 32'd0;
    else if (w_retire) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign CurrentPC   = r_pc;
  assign IMemAddr    = r_pc;
  assign IMemReq     = w_imem_req;
  assign Instruction = r_instr;
  assign InstrValid  = r_valid;
  assign Fault       = r_fault;
  assign RetireCount = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Self-checking bench for pc_fetch_unit: directed boot, fetch,
//                stall, redirect, fault and async-reset scenarios followed by
//                randomized traffic against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        CLK;
  logic        Reset_L;
  logic [31:0] StartPC;
  logic [31:0] NextPC;
  logic [31:0] CurrentPC;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        InstrReady;
  logic        Fault;
  logic [31:0] RetireCount;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: "booted" means the boot edge has happened; a request is
  // outstanding whenever booted, not faulted and no word is held.
  bit          m_booted;
  bit          m_fault;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_count;

  pc_fetch_unit u_dut (
    .CLK         (CLK),
    .Reset_L     (Reset_L),
    .StartPC     (StartPC),
    .NextPC      (NextPC),
    .CurrentPC   (CurrentPC),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemAck     (IMemAck),
    .IMemData    (IMemData),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .Fault       (Fault),
    .RetireCount (RetireCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_booted = 1'b0;
    m_fault  = 1'b0;
    m_valid  = 1'b0;
    m_pc     = 32'd0;
    m_instr  = 32'd0;
    m_count  = 32'd0;
  endfunction

  // One clock edge worth of behaviour, from the inputs present at the edge.
  function automatic void model_step();
    if (!m_booted) begin
      m_booted = 1'b1;
      m_pc     = StartPC;
      if (StartPC[1:0] != 2'b00) m_fault = 1'b1;
    end else if (m_fault) begin
      // terminal
    end else if (!m_valid) begin
      if (IMemAck) begin
        m_instr = IMemData;
        m_valid = 1'b1;
      end
    end else if (InstrReady) begin
      m_pc    = NextPC;
      m_valid = 1'b0;
      m_count = m_count + 32'd1;
      if (NextPC[1:0] != 2'b00) m_fault = 1'b1;
    end
  endfunction

  task automatic compare_all();
    check_eq("CurrentPC",   CurrentPC,   m_pc);
    check_eq("IMemAddr",    IMemAddr,    m_pc);
    check_eq("IMemReq",     {31'd0, IMemReq}, {31'd0, (m_booted && !m_fault && !m_valid)});
    check_eq("InstrValid",  {31'd0, InstrValid}, {31'd0, m_valid});
    check_eq("Instruction", Instruction, m_instr);
    check_eq("Fault",       {31'd0, Fault}, {31'd0, m_fault});
    check_eq("RetireCount", RetireCount, m_count);
  endtask

  // Advance one edge, update the model, then sample 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    if (Reset_L) model_step();
    #1;
    compare_all();
  endtask

  // Pulse reset between edges and check the effect before any clock arrives.
  task automatic async_reset_pulse();
    #2;
    Reset_L = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1;
    Reset_L = 1'b1;
  endtask

  initial begin
    Reset_L    = 1'b0;
    StartPC    = 32'h10;
    NextPC     = 32'h0;
    IMemAck    = 1'b0;
    IMemData   = 32'h0;
    InstrReady = 1'b0;
    model_reset();
    #3;
    compare_all();                       // reset state with no clock yet

    @(posedge CLK); #1;
    compare_all();                       // reset held through an edge
    Reset_L = 1'b1;

    // Boot: first request right after the boot edge.
    tick();
    check_eq("boot_addr", IMemAddr, 32'h10);

    // Fetch and retire.
    IMemAck = 1'b1; IMemData = 32'h8C22_0004;
    tick();
    check_eq("fetched_word", Instruction, 32'h8C22_0004);
    IMemAck = 1'b0; NextPC = 32'h14; InstrReady = 1'b1;
    tick();
    check_eq("retire_pc", CurrentPC, 32'h14);
    check_eq("retire_cnt", RetireCount, 32'd1);
    InstrReady = 1'b0;

    // Memory wait: five cycles without ack, then ack.
    for (int i = 0; i < 5; i++) begin
      InstrReady = i[0];               // ready while nothing is held is ignored
      tick();
    end
    InstrReady = 1'b0;
    IMemAck = 1'b1; IMemData = 32'h1234_5678;
    tick();
    IMemAck = 1'b0;

    // Redirect with stalls.
    NextPC = 32'hF000_0000;
    for (int i = 0; i < 3; i++) begin
      IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF;  // ack ignored while holding
      tick();
      check_eq("stall_pc", CurrentPC, 32'h14);
    end
    IMemAck = 1'b0; InstrReady = 1'b1;
    tick();
    check_eq("jump_pc", CurrentPC, 32'hF000_0000);
    InstrReady = 1'b0;

    // Misaligned retire target.
    IMemAck = 1'b1; IMemData = 32'h0000_0013;
    tick();
    IMemAck = 1'b0; NextPC = 32'h16; InstrReady = 1'b1;
    tick();
    check_eq("fault_pc", CurrentPC, 32'h16);
    NextPC = 32'h20; IMemAck = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    IMemAck = 1'b0; InstrReady = 1'b0;
    async_reset_pulse();

    // Re-boot, get into hold with a non-zero count, then reset mid-hold.
    StartPC = 32'h100;
    tick();
    IMemAck = 1'b1; IMemData = 32'hA;
    tick();
    IMemAck = 1'b0; NextPC = 32'h104; InstrReady = 1'b1;
    tick();
    InstrReady = 1'b0; IMemAck = 1'b1; IMemData = 32'hB;
    tick();
    IMemAck = 1'b0;
    async_reset_pulse();
    IMemAck = 1'b1;                      // late ack while booting is ignored
    tick();
    IMemAck = 1'b0;

    // Misaligned boot address.
    StartPC = 32'h202;
    async_reset_pulse();
    tick();
    tick();

    // Randomized traffic.
    StartPC = 32'h0;
    async_reset_pulse();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      IMemAck    = ($urandom_range(0, 2) != 0);
      IMemData   = $urandom;
      InstrReady = ($urandom_range(0, 2) != 0);
      NextPC     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} |
                   (($urandom_range(0, 40) == 0) ? 32'h1 : 32'h0);
      if ($urandom_range(0, 150) == 0) begin
        StartPC = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} |
                  (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
        async_reset_pulse();
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 CLK  input  1  single system clock; all state SHALL update on its rising edge.
REQ-002 Reset_L  input  1  SHALL be an asynchronous, active-low reset.
REQ-003 StartPC  input  32  boot address, loaded once after reset.
REQ-004 NextPC  input  32  next-PC value from the next-PC logic, sampled only at retire.
REQ-005 CurrentPC  output  32  registered PC; feeds the next-PC logic and instruction memory.
REQ-006 IMemReq  output  1  instruction-memory read request.
REQ-007 IMemAddr  output  32  read address; SHALL equal CurrentPC at all times.
REQ-008 IMemAck  input  1  memory response valid; IMemData is valid in the same cycle.
REQ-009 IMemData  input  32  instruction word from memory.
REQ-010 Instruction  output  32  registered fetched instruction.
REQ-011 InstrValid  output  1  Instruction holds a valid word not yet consumed.
REQ-012 InstrReady  input  1  downstream accepts Instruction this cycle.
REQ-013 Fault  output  1  sticky misaligned-PC flag.
REQ-014 RetireCount  output  32  number of instructions consumed since reset.

Function
REQ-015 The FSM SHALL have four states: BOOT, REQ, HOLD, FAULT.
REQ-016 BOOT: the next edge SHALL load CurrentPC<=StartPC; if StartPC[1:0]!=0, go to FAULT with Fault<=1, else go to REQ.
REQ-017 REQ: IMemReq SHALL be 1 combinationally, with IMemReq=0 in all other states.
REQ-018 REQ with IMemAck=1: the edge SHALL load Instruction<=IMemData and InstrValid<=1, then go to HOLD.
REQ-019 REQ with IMemAck=0: stay in REQ with CurrentPC unchanged and the request held for any number of cycles.
REQ-020 HOLD: InstrValid=1 and Instruction stable; IMemAck SHALL be ignored.
REQ-021 HOLD with InstrReady=1 (retire): CurrentPC<=NextPC, InstrValid<=0, RetireCount<=RetireCount+1.
REQ-022 After a retire, the next state SHALL be REQ if NextPC[1:0]==0; otherwise FAULT with Fault<=1, and CurrentPC still takes NextPC for debug.
REQ-023 HOLD with InstrReady=0: all registers SHALL hold.
REQ-024 FAULT: terminal until reset; no requests, InstrValid=0, CurrentPC frozen, Fault=1.
REQ-025 Minimum throughput: one instruction per 2 cycles (immediate ack, then immediate ready).
REQ-026 RetireCount SHALL wrap from 0xFFFFFFFF to 0 without flagging.
REQ-027 CurrentPC SHALL change only in BOOT or on a retire edge.
REQ-028 NextPC SHALL be sampled only on a retire edge; X on NextPC at any other time SHALL NOT propagate.
REQ-029 InstrReady while InstrValid=0 SHALL have no effect.

Reset
REQ-030 Reset_L=0 SHALL immediately, without waiting for a clock, force: state=BOOT, CurrentPC=0, Instruction=0, InstrValid=0, IMemReq=0, Fault=0, RetireCount=0.
REQ-031 Reset asserted mid-request or mid-hold SHALL abort the transaction; a late IMemAck after reset release SHALL be ignored until REQ is re-entered.
REQ-032 The first request after reset release SHALL appear in the second cycle, after the BOOT edge.

Verification
REQ-033 Boot: StartPC=0x10, release reset -> after one edge CurrentPC=0x10, IMemReq=1, IMemAddr=0x10.
REQ-034 Fetch/retire: ack with IMemData=0x8C220004, then NextPC=0x14 and InstrReady=1 -> Instruction=0x8C220004 and InstrValid=1 for the hold cycle; then CurrentPC=0x14, RetireCount=1, IMemReq=1.
REQ-035 Jump redirect and stalls: in HOLD with NextPC=0xF0000000, InstrReady held 0 for 3 cycles then 1 -> CurrentPC stays 0x14 for 3 cycles, then becomes 0xF0000000.
REQ-036 Memory wait: IMemAck=0 for 5 cycles in REQ -> IMemReq stays 1, IMemAddr stable, InstrValid=0; ack on cycle 6 -> InstrValid=1.
REQ-037 Misaligned: retire with NextPC=0x16 -> Fault=1, CurrentPC=0x16, IMemReq=0 permanently; Reset_L pulse -> Fault=0, CurrentPC=0 asynchronously.
REQ-038 Async reset mid-hold: Reset_L=0 between clock edges while InstrValid=1 -> InstrValid=0 and RetireCount=0 before the next edge.
